median_filter_stream: RTL and testbench
=======================================

Name: median_filter_stream

Overview:
Streaming 3x3 median filter for a multi-channel raster image, one pixel per accepted beat, in raster order.
Holds two line buffers and a 3x3 window, and computes an independent median per channel.
Selectable border handling; flushes the last row and column itself after the final input pixel.
Sits between the pixel source and the frame writer; replaces the whole-row median_filter datapath.

Parameters:
WIDTH, 8, bits per channel sample (unsigned)
CH, 3, channels per pixel; channel 0 in MSBs of the pixel word
IMG_W, 256, columns per frame (>=3)
IMG_H, 256, rows per frame (>=3)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous active-high reset
mode  in  1  border mode: 0 = replicate edge pixels into the window, 1 = border pixels pass through unfiltered; sampled at each accepted in_sof
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat
in_sof  in  1  beat is pixel (0,0) of a frame
in_data  in  CH*WIDTH  input pixel
out_valid  out  1  output pixel valid; single-cycle, no backpressure
out_sof  out  1  output pixel is (0,0)
out_eol  out  1  output pixel is last column of its row
out_data  out  CH*WIDTH  filtered pixel
busy  out  1  frame in progress (RUN or FLUSH)

Behaviour:
- Reset (async): state IDLE; in_ready=1; busy=0; out_valid/out_sof/out_eol=0; out_data=0; counters=0. Line-buffer RAM is not reset.
- Accepted beat = in_valid & in_ready.
- FSM IDLE:
  - Accepted beat with in_sof -> RUN; pixel is (0,0); mode latched.
  - Accepted beat without in_sof is dropped; no output.
- FSM RUN:
  - Each accepted beat is one advance; column/row counters wrap at IMG_W / IMG_H.
  - Accepted in_sof mid-frame aborts: counters restart at (0,0), pending window outputs are discarded, mode is relatched.
  - After pixel (IMG_H-1, IMG_W-1) is accepted -> FLUSH.
- FSM FLUSH:
  - in_ready=0.
  - Generates exactly IMG_W+1 internal advances, one per cycle, with no input.
  - Then -> IDLE; busy falls in the cycle IDLE is entered.
- Output ordering: output pixel n (raster index) is produced by advance n+IMG_W+1, so the window centre lags input by one row plus one pixel.
  - out_valid asserts exactly 2 cycles after that advance: one cycle for the window register, one for the median register.
  - Exactly IMG_W*IMG_H outputs per frame, in raster order.
  - Outputs of a frame still in the pipe when a new frame starts are emitted normally.
- Window taps outside the image:
  - mode 0: use the nearest in-image pixel (clamp row/column).
  - mode 1: any output with row 0, row IMG_H-1, col 0 or col IMG_W-1 carries the centre pixel unmodified.
- Median per channel:
  - Unsigned compare over 9 samples; result = 5th smallest.
  - Ties are irrelevant to the value; no rounding, width preserved.
- Gaps in in_valid stall the window with no output bubble artefacts. Counters and line buffers advance only on advances.
- out_sof with the first output pixel; out_eol when output column = IMG_W-1.
- Reset mid-frame: outputs zero immediately, in-flight data is lost, next in_sof starts cleanly.

Decomposition:
- Package median_pkg:
  - localparams PIX_W = CH*WIDTH, COL_BITS = $clog2(IMG_W), ROW_BITS = $clog2(IMG_H)
  - FSM state enum (IDLE, RUN, FLUSH)
  - border-mode constants
- Sub-module median9:
  - purely combinational 19-stage compare-exchange network on WIDTH-bit unsigned samples
  - instantiated CH times
- Line buffers are two IMG_W-deep PIX_W-wide arrays inside the top module.

Test Plan:
1. IMG_W=IMG_H=4, CH=3, mode 0, all channels 0x40 streamed back-to-back -> 16 outputs all 0x404040; out_sof on the first; out_eol on outputs 3,7,11,15; in_ready low for exactly 5 cycles; first out_valid 2 cycles after the advance for index 5.
2. Salt noise, mode 0: all 0x10 except (1,1)=0xFF on channel 0 -> output (1,1) channel 0 = 0x10; all outputs 0x101010.
3. Ramp value r*4+c on all channels:
   - mode 1 -> (1,1)=5, (2,2)=10, (0,0)=0 and (3,3)=15 unfiltered.
   - mode 0 -> (0,0)=1, window {0,0,1,0,0,1,4,4,5}.
4. Channel independence: ch0 ramp, ch1 constant 0x80, ch2 = 0xFF-ramp -> ch1 always 0x80; ch0 and ch2 match per-channel golden values.
5. in_valid toggling every other cycle, frame as in scenario 3 -> identical 16-pixel output sequence, no duplicates or drops; busy high until the final flush advance.
6. RST pulse after 7 accepted beats -> out_valid=0 and in_ready=1 immediately; a following clean frame from scenario 1 gives the correct 16 outputs.
   Non-sof beat in IDLE -> no output.

Source files
------------

// File: rtl/median_pkg.sv
// Shared types and helpers for the streaming 3x3 median filter.
// Defaults here seed the top-level parameters; the top recomputes derived widths.
package median_pkg;

  localparam int WIDTH_D  = 8;
  localparam int CH_D     = 3;
  localparam int IMG_W_D  = 256;
  localparam int IMG_H_D  = 256;
  localparam int PIX_W    = CH_D * WIDTH_D;
  localparam int COL_BITS = $clog2(IMG_W_D);
  localparam int ROW_BITS = $clog2(IMG_H_D);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam logic MODE_REPLICATE = 1'b0;
  localparam logic MODE_PASS      = 1'b1;

  // Map a window tap index to the centre index when that side lies outside the image.
  function automatic logic [1:0] clamp_idx(input logic [1:0] idx, input logic lo, input logic hi);
    logic [1:0] res;
    res = idx;
    if (((idx == 2'd0) && lo) || ((idx == 2'd2) && hi)) begin
      res = 2'd1;
    end else begin
      res = idx;
    end
    return res;
  endfunction

endpackage

// File: rtl/median_filter_stream_median9.sv
// Combinational median of nine unsigned samples using a 19-stage compare-exchange network.
module median9 #(
  parameter int WIDTH = 8
) (
  input  logic [9*WIDTH-1:0] i_samp,
  output logic [WIDTH-1:0]   o_med
);

  logic [9*WIDTH-1:0] w_net;

  function automatic logic [9*WIDTH-1:0] cx(input logic [9*WIDTH-1:0] v, input int a, input int b);
    logic [9*WIDTH-1:0] r;
    logic [WIDTH-1:0]   x;
    logic [WIDTH-1:0]   y;
    r = v;
    x = v[a*WIDTH +: WIDTH];
    y = v[b*WIDTH +: WIDTH];
    if (x > y) begin
      r[a*WIDTH +: WIDTH] = y;
      r[b*WIDTH +: WIDTH] = x;
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Partial sort: only the element landing in slot 4 is guaranteed to be the median.
  always_comb begin
    w_net = i_samp;
    w_net = cx(w_net, 1, 2);
    w_net = cx(w_net, 4, 5);
    w_net = cx(w_net, 7, 8);
    w_net = cx(w_net, 0, 1);
    w_net = cx(w_net, 3, 4);
    w_net = cx(w_net, 6, 7);
    w_net = cx(w_net, 1, 2);
    w_net = cx(w_net, 4, 5);
    w_net = cx(w_net, 7, 8);
    w_net = cx(w_net, 0, 3);
    w_net = cx(w_net, 5, 8);
    w_net = cx(w_net, 4, 7);
    w_net = cx(w_net, 3, 6);
    w_net = cx(w_net, 1, 4);
    w_net = cx(w_net, 2, 5);
    w_net = cx(w_net, 4, 7);
    w_net = cx(w_net, 4, 2);
    w_net = cx(w_net, 6, 4);
    w_net = cx(w_net, 4, 2);
    o_med = w_net[4*WIDTH +: WIDTH];
  end

endmodule

// File: rtl/median_filter_stream.sv
// Streaming 3x3 per-channel median filter with two line buffers and self-flush.
// Output centre lags the input by one row plus one pixel; edge taps are clamped or bypassed.
module median_filter_stream
  import median_pkg::*;
#(
  parameter int WIDTH = WIDTH_D,
  parameter int CH    = CH_D,
  parameter int IMG_W = IMG_W_D,
  parameter int IMG_H = IMG_H_D
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                mode,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_sof,
  input  logic [CH*WIDTH-1:0] in_data,
  output logic                out_valid,
  output logic                out_sof,
  output logic                out_eol,
  output logic [CH*WIDTH-1:0] out_data,
  output logic                busy
);

  localparam int PW = CH * WIDTH;
  localparam int CB = $clog2(IMG_W);
  localparam int RB = $clog2(IMG_H + 2);

  state_e         r_state;
  state_e         w_next;
  logic [CB-1:0]  r_col;
  logic [RB-1:0]  r_row;
  logic [CB-1:0]  r_ocol;
  logic [RB-1:0]  r_orow;
  logic           r_mode;
  logic [PW-1:0]  r_lb0 [IMG_W];
  logic [PW-1:0]  r_lb1 [IMG_W];
  logic [PW-1:0]  r_win [3][3];
  logic           r_s1_valid, r_s1_top, r_s1_bot, r_s1_left, r_s1_right, r_s1_sof, r_s1_mode;

  logic           w_accept, w_start, w_adv, w_emit, w_last_in, w_flush_done, w_border;
  logic [CB-1:0]  w_col;
  logic [PW-1:0]  w_pix;
  logic [PW-1:0]  w_cw [3][3];
  logic [PW-1:0]  w_med;

  assign in_ready     = (r_state != FLUSH);
  assign busy         = (r_state != IDLE);
  assign w_accept     = in_valid & in_ready;
  assign w_start      = w_accept & in_sof;
  assign w_adv        = (r_state == FLUSH) | w_start | (w_accept & (r_state == RUN));
  assign w_col        = w_start ? {CB{1'b0}} : r_col;
  assign w_pix        = (r_state == FLUSH) ? {PW{1'b0}} : in_data;
  assign w_emit       = w_adv & ~w_start &
                        ((r_row > RB'(1)) | ((r_row == RB'(1)) & (r_col != {CB{1'b0}})));
  assign w_last_in    = (r_row == RB'(IMG_H - 1)) & (r_col == CB'(IMG_W - 1));
  assign w_flush_done = (r_row == RB'(IMG_H + 1));

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic; a frame ends after IMG_W+1 flush advances (row IMG_H+1, col 0).
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  w_next = w_start ? RUN : IDLE;
      RUN: begin
        if (w_start)                    w_next = RUN;
        else if (w_accept && w_last_in) w_next = FLUSH;
        else                            w_next = RUN;
      end
      FLUSH: w_next = w_flush_done ? IDLE : FLUSH;
      default: w_next = IDLE;
    endcase
  end

  // Line buffers: previous two rows, indexed by input column; not reset.
  always_ff @(posedge CLK) begin
    if (w_adv) begin
      r_lb0[w_col] <= w_pix;
      r_lb1[w_col] <= r_lb0[w_col];
    end
  end

  // Window shift, raster counters and stage-1 border flags for the emitted centre.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_col      <= {CB{1'b0}};
      r_row      <= {RB{1'b0}};
      r_ocol     <= {CB{1'b0}};
      r_orow     <= {RB{1'b0}};
      r_mode     <= MODE_REPLICATE;
      r_s1_valid <= 1'b0;
      r_s1_top   <= 1'b0;
      r_s1_bot   <= 1'b0;
      r_s1_left  <= 1'b0;
      r_s1_right <= 1'b0;
      r_s1_sof   <= 1'b0;
      r_s1_mode  <= MODE_REPLICATE;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          r_win[r][c] <= {PW{1'b0}};
    end else begin
      r_s1_valid <= w_emit;
      if (w_adv) begin
        for (int r = 0; r < 3; r++) begin
          r_win[r][0] <= r_win[r][1];
          r_win[r][1] <= r_win[r][2];
        end
        r_win[0][2] <= r_lb1[w_col];
        r_win[1][2] <= r_lb0[w_col];
        r_win[2][2] <= w_pix;
        if (w_start) begin
          r_col  <= CB'(1);
          r_row  <= {RB{1'b0}};
          r_ocol <= {CB{1'b0}};
          r_orow <= {RB{1'b0}};
          r_mode <= mode;
        end else begin
          if (r_col == CB'(IMG_W - 1)) begin
            r_col <= {CB{1'b0}};
            r_row <= r_row + RB'(1);
          end else begin
            r_col <= r_col + CB'(1);
          end
          if (w_emit) begin
            r_s1_top   <= (r_orow == {RB{1'b0}});
            r_s1_bot   <= (r_orow == RB'(IMG_H - 1));
            r_s1_left  <= (r_ocol == {CB{1'b0}});
            r_s1_right <= (r_ocol == CB'(IMG_W - 1));
            r_s1_sof   <= (r_orow == {RB{1'b0}}) && (r_ocol == {CB{1'b0}});
            r_s1_mode  <= r_mode;
            if (r_ocol == CB'(IMG_W - 1)) begin
              r_ocol <= {CB{1'b0}};
              r_orow <= (r_orow == RB'(IMG_H - 1)) ? {RB{1'b0}} : r_orow + RB'(1);
            end else begin
              r_ocol <= r_ocol + CB'(1);
            end
          end
        end
      end
    end
  end

  // Clamped window: out-of-image taps fold onto the centre row/column.
  always_comb begin
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w_cw[r][c] = r_win[clamp_idx(2'(r), r_s1_top, r_s1_bot)][clamp_idx(2'(c), r_s1_left, r_s1_right)];
  end

  for (genvar ch = 0; ch < CH; ch++) begin : g_ch
    logic [9*WIDTH-1:0] w_samp;

    // Gather this channel's nine taps.
    always_comb begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          w_samp[(r*3+c)*WIDTH +: WIDTH] = w_cw[r][c][(CH-1-ch)*WIDTH +: WIDTH];
    end

    median9 #(.WIDTH(WIDTH)) u_med (
      .i_samp (w_samp),
      .o_med  (w_med[(CH-1-ch)*WIDTH +: WIDTH])
    );
  end

  assign w_border = (r_s1_mode == MODE_PASS) & (r_s1_top | r_s1_bot | r_s1_left | r_s1_right);

  // Output register stage.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
      out_data  <= {PW{1'b0}};
    end else begin
      out_valid <= r_s1_valid;
      out_sof   <= r_s1_valid & r_s1_sof;
      out_eol   <= r_s1_valid & r_s1_right;
      if (r_s1_valid) out_data <= w_border ? r_win[1][1] : w_med;
    end
  end

endmodule

// File: tb/tb_median_filter_stream.sv
// Self-checking bench: directed and random 4x4 frames against a sort-based reference model.
module tb_median_filter_stream;

  localparam int W  = 8;
  localparam int C  = 3;
  localparam int IW = 4;
  localparam int IH = 4;
  localparam int N  = IW * IH;
  localparam int PW = W * C;

  logic          CLK, RST, mode, in_valid, in_ready, in_sof;
  logic          out_valid, out_sof, out_eol, busy;
  logic [PW-1:0] in_data, out_data;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [PW-1:0] frame [N];
  logic [PW-1:0] cap_d [$];
  logic          cap_s [$];
  logic          cap_e [$];
  int            cap_c [$];

  median_filter_stream #(.WIDTH(W), .CH(C), .IMG_W(IW), .IMG_H(IH)) dut (
    .CLK(CLK), .RST(RST), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .in_sof(in_sof), .in_data(in_data), .out_valid(out_valid), .out_sof(out_sof),
    .out_eol(out_eol), .out_data(out_data), .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (out_valid === 1'b1) begin
      cap_d.push_back(out_data);
      cap_s.push_back(out_sof);
      cap_e.push_back(out_eol);
      cap_c.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] cap_at(input int j);
    if (j < cap_d.size()) return cap_d[j];
    return {PW{1'bx}};
  endfunction

  function automatic int clampi(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  // Reference: gather the clamped 3x3 neighbourhood, sort it, take the 5th smallest.
  function automatic logic [PW-1:0] ref_pix(input bit m, input int r, input int c);
    logic [PW-1:0] res, px;
    int v [9];
    int k, t;
    if (m && (r == 0 || r == IH-1 || c == 0 || c == IW-1)) return frame[r*IW+c];
    res = '0;
    for (int ch = 0; ch < C; ch++) begin
      k = 0;
      for (int dr = -1; dr <= 1; dr++)
        for (int dc = -1; dc <= 1; dc++) begin
          px = frame[clampi(r+dr, IH-1)*IW + clampi(c+dc, IW-1)];
          v[k] = int'(px[(C-1-ch)*W +: W]);
          k++;
        end
      for (int i = 0; i < 9; i++)
        for (int j = 0; j < 8 - i; j++)
          if (v[j] > v[j+1]) begin t = v[j]; v[j] = v[j+1]; v[j+1] = t; end
      res[(C-1-ch)*W +: W] = W'(v[4]);
    end
    return res;
  endfunction

  // Stream the current frame; gm: 0 = back-to-back, 1 = every other cycle, 2 = random gaps.
  task automatic run_frame(input string name, input bit m, input int gm);
    int c5, last, g, rdy_lo, bfall;
    c5 = 0; last = 0; rdy_lo = 0; bfall = -1;
    @(negedge CLK);
    cap_d.delete(); cap_s.delete(); cap_e.delete(); cap_c.delete();
    for (int i = 0; i < N; i++) begin
      g = (i == 0) ? 0 : (gm == 1) ? 1 : (gm == 2) ? int'($urandom_range(0, 2)) : 0;
      repeat (g) begin in_valid = 1'b0; in_sof = 1'b0; @(negedge CLK); end
      in_valid = 1'b1; in_sof = (i == 0); in_data = frame[i]; mode = m;
      if (i == 5) c5 = cyc;
      last = cyc;
      @(negedge CLK);
    end
    in_valid = 1'b0; in_sof = 1'b0;
    for (int t = 0; t < 40; t++) begin
      if (in_ready !== 1'b1) rdy_lo++;
      if (bfall < 0 && busy === 1'b0) bfall = cyc - last;
      @(negedge CLK);
    end
    chk({name, " count"}, cap_d.size(), N);
    chk({name, " ready_low_cycles"}, rdy_lo, IW + 1);
    chk({name, " busy_fall"}, bfall, IW + 2);
    if (cap_c.size() > 0) chk({name, " first_latency"}, cap_c[0] - c5, 2);
    for (int j = 0; j < N && j < cap_d.size(); j++) begin
      chk($sformatf("%s out%0d data", name, j), cap_d[j], ref_pix(m, j / IW, j % IW));
      chk($sformatf("%s out%0d sof", name, j), cap_s[j], (j == 0));
      chk($sformatf("%s out%0d eol", name, j), cap_e[j], (j % IW == IW - 1));
    end
  endtask

  initial begin
    RST = 1'b1; mode = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_data = '0;
    repeat (2) @(negedge CLK);
    chk("reset in_ready", in_ready, 1);
    chk("reset busy", busy, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset out_sof", out_sof, 0);
    chk("reset out_eol", out_eol, 0);
    chk("reset out_data", out_data, 0);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    for (int i = 0; i < N; i++) frame[i] = 24'h404040;
    run_frame("flat", 1'b0, 0);
    chk("flat pix0", cap_at(0), 24'h404040);

    for (int i = 0; i < N; i++) frame[i] = 24'h101010;
    frame[5] = 24'hFF1010;
    run_frame("salt", 1'b0, 0);
    chk("salt pix(1,1)", cap_at(5), 24'h101010);

    for (int i = 0; i < N; i++) frame[i] = {3{8'(i)}};
    run_frame("ramp_m1", 1'b1, 0);
    chk("ramp_m1 (1,1)", cap_at(5), 24'h050505);
    chk("ramp_m1 (2,2)", cap_at(10), 24'h0A0A0A);
    chk("ramp_m1 (0,0)", cap_at(0), 24'h000000);
    chk("ramp_m1 (3,3)", cap_at(15), 24'h0F0F0F);
    run_frame("ramp_m0", 1'b0, 0);
    chk("ramp_m0 (0,0)", cap_at(0), 24'h010101);

    for (int i = 0; i < N; i++) frame[i] = {8'(i * 9), 8'h80, 8'(8'hFF - 8'(i * 9))};
    run_frame("chan", 1'b0, 0);
    for (int j = 0; j < cap_d.size(); j++) chk($sformatf("chan ch1 out%0d", j), cap_d[j][15:8], 8'h80);

    for (int i = 0; i < N; i++) frame[i] = {3{8'(i)}};
    run_frame("gaps", 1'b0, 1);
    chk("gaps (0,0)", cap_at(0), 24'h010101);

    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < N; i++) frame[i] = PW'($urandom);
      run_frame($sformatf("rand%0d", f), 1'($urandom_range(0, 1)), 2);
    end

    for (int i = 0; i < N; i++) frame[i] = {3{8'(i)}};
    @(negedge CLK);
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; in_sof = (i == 0); in_data = frame[i]; mode = 1'b0;
      @(negedge CLK);
    end
    in_valid = 1'b0; in_sof = 1'b0;
    RST = 1'b1;
    #1;
    chk("midrst out_valid", out_valid, 0);
    chk("midrst in_ready", in_ready, 1);
    chk("midrst busy", busy, 0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    for (int i = 0; i < N; i++) frame[i] = 24'h404040;
    run_frame("post_rst", 1'b0, 0);

    @(negedge CLK);
    cap_d.delete(); cap_s.delete(); cap_e.delete(); cap_c.delete();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_sof = 1'b0; in_data = 24'h123456;
      @(negedge CLK);
    end
    in_valid = 1'b0;
    repeat (10) @(negedge CLK);
    chk("idle_nosof outputs", cap_d.size(), 0);
    chk("idle_nosof busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
